serial_twoscomp_unit: RTL and testbench

Bit-serial, LSB-first signed arithmetic unit for fixed-width words. Each word is processed with one of four selectable operations: pass, negate, increment or decrement. It is the parametrised successor to our single-mode serial negator. It adds:
- word framing via a bit counter;
- a valid/start-of-word handshake;
- per-word mode selection;
- signed-overflow reporting on the word's MSB.

It sits between serial shift-register front ends and downstream serial consumers.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_bitcnt.sv | 39 +++
 rtl/serial_twoscomp_unit.sv | 108 ++++++++++
 tb/tb_serial_twoscomp_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the bit-serial arithmetic units: operation modes and counter width.
package serial_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        NEG  = 2'b01,
        INC  = 2'b10,
        DEC  = 2'b11
    } mode_t;

    typedef logic [$clog2(MAX_WIDTH)-1:0] bcnt_t;

    // Every arithmetic mode starts the word with a pending carry/borrow of one.
    function automatic logic carry_init(mode_t m);
        return m != PASS;
    endfunction

endpackage

// File: rtl/serial_bitcnt.sv
// Word framing counter: tracks the bit index within a serial word and flags
// the first and last (MSB) bit of each word.
module serial_bitcnt
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  restart,
    output bcnt_t bcnt,
    output logic  first,
    output logic  msb
);

    localparam bcnt_t LAST_IDX = bcnt_t'(WIDTH - 1);

    // A restart makes the current bit index 0, so it can never also be the MSB.
    assign first = en & (restart | (bcnt == '0));
    assign msb   = en & ~first & (bcnt == LAST_IDX);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            bcnt <= '0;
        end else if (en) begin
            if (first) begin
                bcnt <= bcnt_t'(1);
            end else if (msb) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + bcnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/serial_twoscomp_unit.sv
// Bit-serial LSB-first pass/negate/increment/decrement unit with 1-cycle latency.
// Define SERIAL_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_twoscomp_unit
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       sow,
    input  logic       a,
    input  logic [1:0] mode,
    output logic       out_valid,
    output logic       n,
    output logic       last,
    output logic       ovf
);

    mode_t mode_q;
    mode_t mode_cur;
    logic  c;
    logic  c_cur;
    logic  c_next;
    logic  r;
    logic  first;
    logic  msb;
    bcnt_t unused_bcnt;

    serial_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk     (clk),
        .reset   (reset),
        .en      (in_valid),
        .restart (sow & in_valid),
        .bcnt    (unused_bcnt),
        .first   (first),
        .msb     (msb)
    );

    // Bit 0 of a word must see the new mode and the freshly initialised carry.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        mode_cur = first ? mode_t'(mode) : mode_q;
        c_cur    = first ? carry_init(mode_t'(mode)) : c;
        r        = a;
        c_next   = 1'b0;
        unique case (mode_cur)
            PASS: ;
            NEG: begin
                r      = ~a ^ c_cur;
                c_next = ~a & c_cur;
            end
            INC: begin
                r      = a ^ c_cur;
                c_next = a & c_cur;
            end
            DEC: begin
                r      = a ^ c_cur;
                c_next = ~a & c_cur;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c         <= 1'b0;
            mode_q    <= PASS;
            out_valid <= 1'b0;
            n         <= 1'b0;
            last      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            n         <= in_valid & r;
            last      <= msb;
            if (in_valid) begin
                c      <= c_next;
                mode_q <= mode_cur;
            end
        end
    end

`ifdef SERIAL_OVF_EN
    logic ovf_bit;

    // Sign rules: only meaningful on the MSB, where a and r are the sign bits.
    always_comb begin
        ovf_bit = 1'b0;
        unique case (mode_cur)
            PASS: ovf_bit = 1'b0;
            NEG:  ovf_bit = a & r;
            INC:  ovf_bit = ~a & r;
            DEC:  ovf_bit = a & ~r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else begin
            ovf <= msb & ovf_bit;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_twoscomp_unit.sv
// Scoreboard bench for serial_twoscomp_unit (WIDTH=8): stimulus pushes expected
// output bits, a negedge monitor pops and compares whenever out_valid is high.
module tb_serial_twoscomp_unit;
    import serial_pkg::*;

`ifdef SERIAL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic n;
        logic last;
        logic ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       sow;
    logic       a;
    logic [1:0] mode;
    logic       out_valid;
    logic       n;
    logic       last;
    logic       ovf;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   out_idx = 0;
    bit   idle_pending = 1'b0;

    serial_twoscomp_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .sow       (sow),
        .a         (a),
        .mode      (mode),
        .out_valid (out_valid),
        .n         (n),
        .last      (last),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid output bit must match the next scoreboard entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check($sformatf("unexpected_out[%0d]", out_idx), 32'(out_valid), 32'(1'b0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("n[%0d]", out_idx), 32'(n), 32'(e.n));
                check($sformatf("last[%0d]", out_idx), 32'(last), 32'(e.last));
                check($sformatf("ovf[%0d]", out_idx), 32'(ovf), 32'(e.ovf));
            end
            out_idx++;
        end
    end

    // Drive nbits of val; expected result bits come from hand-computed exp_r.
    // Non-first bits carry a different mode to show the word's mode is latched.
    task automatic send_word(input mode_t m, input logic [7:0] val, input logic [7:0] exp_r,
                             input logic exp_ovf, input logic use_sow, input int nbits,
                             input int gap_after, input int gap_len);
        logic [1:0] mv;
        exp_t       e;
        mv = m;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (idle_pending) check("idle_out_valid", 32'(out_valid), 32'(1'b0));
            idle_pending = 1'b0;
            in_valid = 1'b1;
            a        = val[i];
            sow      = (i == 0) && use_sow;
            mode     = (i == 0) ? mv : ~mv;
            e.n      = exp_r[i];
            e.last   = (i == 7);
            e.ovf    = (i == 7) && exp_ovf && OVF_EN;
            q.push_back(e);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    if (g > 0) check("gap_out_valid", 32'(out_valid), 32'(1'b0));
                    in_valid = 1'b0;
                    sow      = 1'b0;
                    a        = 1'($urandom);
                end
                idle_pending = (gap_len > 0);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid     = 1'b0;
        sow          = 1'b0;
        idle_pending = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        sow      = 1'b0;
        a        = 1'b0;
        mode     = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'(1'b0));
        check("reset_n", 32'(n), 32'(1'b0));
        check("reset_last", 32'(last), 32'(1'b0));
        check("reset_ovf", 32'(ovf), 32'(1'b0));
        reset = 1'b0;
        idle();

        // Contiguous stream of words; only the first uses sow, the rest rely on wrap.
        send_word(NEG, 8'h05, 8'hFB, 1'b0, 1'b1, 8, -1, 0);
        send_word(NEG, 8'h80, 8'h80, 1'b1, 1'b0, 8, -1, 0);
        send_word(NEG, 8'h00, 8'h00, 1'b0, 1'b0, 8, -1, 0);
        send_word(INC, 8'h7F, 8'h80, 1'b1, 1'b0, 8, -1, 0);
        send_word(DEC, 8'h00, 8'hFF, 1'b0, 1'b0, 8, -1, 0);
        send_word(DEC, 8'h80, 8'h7F, 1'b1, 1'b0, 8, -1, 0);
        idle();

        send_word(PASS, 8'hA5, 8'hA5, 1'b0, 1'b1, 8, -1, 0);
        send_word(INC, 8'hFF, 8'h00, 1'b0, 1'b0, 8, -1, 0);
        idle();

        // Three idle cycles after bit 2.
        send_word(NEG, 8'h03, 8'hFD, 1'b0, 1'b1, 8, 2, 3);
        idle();

        // Abandoned word restarted by sow on its 4th bit.
        send_word(NEG, 8'h05, 8'hFB, 1'b0, 1'b1, 3, -1, 0);
        send_word(INC, 8'h01, 8'h02, 1'b0, 1'b1, 8, -1, 0);
        idle();

        // Abandoned word cut by reset; the bit presented with reset is dropped.
        send_word(NEG, 8'h05, 8'hFB, 1'b0, 1'b1, 3, -1, 0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 1'b1;
        mode     = 2'b01;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_mid_n", 32'(n), 32'(1'b0));
        check("rst_mid_last", 32'(last), 32'(1'b0));
        check("rst_mid_ovf", 32'(ovf), 32'(1'b0));
        idle_pending = 1'b1;
        send_word(INC, 8'h01, 8'h02, 1'b0, 1'b0, 8, -1, 0);
        idle();

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
